// File: rtl/mips_debug_pkg.sv
// mips_debug_pkg
// Shared definitions for the MIPS debug unit: the serializer state encoding,
// the dump terminator character, the byte count of each pipeline latch image
// and the host command codes that select which latch is dumped.
package mips_debug_pkg;

    // Serializer FSM states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WAIT     = 3'd2,
        ST_RDY_SEND = 3'd3,
        ST_RDY_WAIT = 3'd4,
        ST_DONE     = 3'd5
    } ser_state_t;

    // Terminator the host waits for after every dump ('R')
    localparam logic [7:0] READY_CHAR = 8'h52;

    // Payload bytes per latch image, padded to whole bytes
    localparam int IF_ID_BYTES  = 8;
    localparam int ID_EX_BYTES  = 17;
    localparam int EX_MEM_BYTES = 10;
    localparam int MEM_WB_BYTES = 9;

    // Host command codes selecting the latch to dump
    localparam logic [7:0] CMD_DUMP_IF_ID  = 8'h02;
    localparam logic [7:0] CMD_DUMP_ID_EX  = 8'h03;
    localparam logic [7:0] CMD_DUMP_EX_MEM = 8'h04;
    localparam logic [7:0] CMD_DUMP_MEM_WB = 8'h05;

endpackage

// File: rtl/debug_latch_serializer.sv
// debug_latch_serializer
// Captures a pipeline latch image on a start request and sends it to uart_tx
// one byte at a time, least-significant byte first, then sends READY_CHAR so
// the host knows the dump is complete.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_start      one-cycle dump request, honoured only when idle
//   i_data       latch image, zero-extended, sampled on an accepted start
//   i_num_bytes  payload byte count, clamped to MAX_BYTES
//   o_tx_data    byte presented to uart_tx, held until its done pulse
//   o_tx_start   one-cycle transmit request to uart_tx
//   i_tx_done    uart_tx completion pulse for the current byte
//   o_busy       high from accept until the terminator has completed
//   o_done       one-cycle pulse after the terminator has completed
module debug_latch_serializer #(
    parameter int               DATA_WIDTH = 136,
    parameter int               MAX_BYTES  = DATA_WIDTH / 8,
    parameter int               CNT_WIDTH  = 5,
    parameter logic [7:0]       READY_CHAR = mips_debug_pkg::READY_CHAR
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [CNT_WIDTH-1:0]  i_num_bytes,
    output logic [7:0]            o_tx_data,
    output logic                  o_tx_start,
    input  logic                  i_tx_done,
    output logic                  o_busy,
    output logic                  o_done
);

    import mips_debug_pkg::*;

    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_BYTES);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT = CNT_WIDTH'(1);

    ser_state_t            state;
    logic [DATA_WIDTH-1:0] shreg;
    logic [CNT_WIDTH-1:0]  cnt;
    logic [CNT_WIDTH-1:0]  load_cnt;
    logic                  done_seen;

    // Requested byte count limited to what the image can hold.
    always_comb begin
        load_cnt = (i_num_bytes > MAX_CNT) ? MAX_CNT : i_num_bytes;
    end

    // A done pulse is only meaningful once the start pulse for the current
    // byte has been issued; one arriving alongside the start belongs to an
    // earlier frame and is dropped.
    always_comb begin
        done_seen = i_tx_done && !o_tx_start;
    end

    // Serializer FSM. The first payload byte is launched on the accepting
    // edge itself (the SEND work is folded into IDLE) so its start pulse
    // appears the cycle after the request; every later byte goes through
    // SEND, giving a two-cycle gap after each done pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            shreg      <= '0;
            cnt        <= '0;
            o_tx_data  <= '0;
            o_tx_start <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            o_tx_start <= 1'b0;
            o_done     <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        shreg  <= i_data;
                        o_busy <= 1'b1;
                        if (load_cnt != '0) begin
                            o_tx_start <= 1'b1;
                            o_tx_data  <= i_data[7:0];
                            cnt        <= load_cnt - ONE_CNT;
                            state      <= ST_WAIT;
                        end else begin
                            cnt   <= '0;
                            state <= ST_RDY_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    o_tx_start <= 1'b1;
                    o_tx_data  <= shreg[7:0];
                    cnt        <= cnt - ONE_CNT;
                    state      <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_seen) begin
                        shreg <= shreg >> 8;
                        state <= (cnt != '0) ? ST_SEND : ST_RDY_SEND;
                    end
                end
                ST_RDY_SEND: begin
                    o_tx_start <= 1'b1;
                    o_tx_data  <= READY_CHAR;
                    state      <= ST_RDY_WAIT;
                end
                ST_RDY_WAIT: begin
                    if (done_seen) begin
                        o_done <= 1'b1;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    o_busy <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
